// File: rtl/program_sequencer_if.sv
// Decoder/debug/ROM-side signal bundle for program_sequencer.
// The slave modport is the sequencer. The master modport is the core that drives it.
interface program_sequencer_if #(
    parameter int unsigned PC_W  = 4,
    parameter int unsigned CNT_W = 8
);
    logic             jump;
    logic             conditional_jump;
    logic [PC_W-1:0]  jump_address;
    logic             zero_flag;
    logic             halt_req;
    logic             step_req;
    logic [PC_W-1:0]  pm_addr;
    logic [PC_W-1:0]  pc;
    logic             hold;
    logic             halted;
    logic [CNT_W-1:0] retired;
    logic [7:0]       from_PS;

    modport slave (
        input  jump, conditional_jump, jump_address, zero_flag, halt_req, step_req,
        output pm_addr, pc, hold, halted, retired, from_PS
    );

    modport master (
        output jump, conditional_jump, jump_address, zero_flag, halt_req, step_req,
        input  pm_addr, pc, hold, halted, retired, from_PS
    );
endinterface

// File: rtl/program_sequencer.sv
// Program counter, ROM addressing, jump resolution, boot cycle and retired-instruction count.
// Define PS_DEBUG_EN to enable the HALT/STEP debug controller; without it the FSM is BOOT->RUN only.
module program_sequencer #(
    parameter int unsigned PC_W  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    program_sequencer_if.slave   bus
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
`ifdef PS_DEBUG_EN
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_STEP = 2'd3;
`endif

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             take_jump;
    logic [PC_W-1:0]  exec_addr;
    logic [PC_W-1:0]  pm_addr_c;
    logic             hold_c;

    // Address of the instruction that follows the one in ir when it executes.
    always_comb begin
        take_jump = bus.jump | (bus.conditional_jump & ~bus.zero_flag);
        exec_addr = take_jump ? bus.jump_address : pc_q + PC_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        pm_addr_c = '0;
        hold_c    = 1'b1;
        case (state_q)
            S_BOOT: begin
                pm_addr_c = '0;
                pc_d      = '0;
                hold_c    = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                pm_addr_c = exec_addr;
                pc_d      = exec_addr;
                retired_d = retired_q + CNT_W'(1);
                hold_c    = 1'b0;
`ifdef PS_DEBUG_EN
                if (bus.halt_req) state_d = S_HALT;
`endif
            end
`ifdef PS_DEBUG_EN
            // ir reloads the instruction at pc so it is still pending when execution resumes.
            S_HALT: begin
                pm_addr_c = pc_q;
                hold_c    = 1'b1;
                if (bus.step_req)      state_d = S_STEP;
                else if (!bus.halt_req) state_d = S_RUN;
            end
            S_STEP: begin
                pm_addr_c = exec_addr;
                pc_d      = exec_addr;
                retired_d = retired_q + CNT_W'(1);
                hold_c    = 1'b0;
                state_d   = S_HALT;
            end
`endif
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_BOOT;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign bus.pm_addr = pm_addr_c;
    assign bus.pc      = pc_q;
    assign bus.hold    = hold_c;
    assign bus.retired = retired_q;
    assign bus.from_PS = 8'(pc_q);

`ifdef PS_DEBUG_EN
    assign bus.halted = (state_q == S_HALT);
`else
    logic unused_debug;
    assign unused_debug = &{1'b0, bus.halt_req, bus.step_req};
    assign bus.halted   = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus queues expected outputs, a negedge monitor checks them.
// Covers boot, sequential wrap, jumps, debug halt/step (or its absence), async reset and counter wrap.
module tb_program_sequencer;

    logic clk;
    logic reset;

    program_sequencer_if #(.PC_W(4), .CNT_W(8)) bus ();

    program_sequencer #(.PC_W(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [3:0] pc;
        logic [3:0] pm;
        logic       hold;
        logic       halted;
        logic [7:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s got %0h want %0h", name, fld, got, want);
        end
    endtask

    // Monitor: the expected record for each cycle is compared mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, "pc",      32'(bus.pc),      32'(e.pc));
            chk(e.name, "pm_addr", 32'(bus.pm_addr), 32'(e.pm));
            chk(e.name, "hold",    32'(bus.hold),    32'(e.hold));
            chk(e.name, "halted",  32'(bus.halted),  32'(e.halted));
            chk(e.name, "retired", 32'(bus.retired), 32'(e.ret));
            chk(e.name, "from_PS", 32'(bus.from_PS), {24'h0, 4'h0, e.pc});
        end
    end

    task automatic push(input string name, input logic [3:0] epc, input logic [3:0] epm,
                        input logic eh, input logic ehd, input logic [7:0] eret);
        exp_t e;
        e.name = name; e.pc = epc; e.pm = epm; e.hold = eh; e.halted = ehd; e.ret = eret;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input string name, input logic rst,
                       input logic j, input logic cj, input logic [3:0] ja, input logic zf,
                       input logic hr, input logic sr,
                       input logic [3:0] epc, input logic [3:0] epm,
                       input logic eh, input logic ehd, input logic [7:0] eret);
        @(posedge clk);
        #1;
        reset                = rst;
        bus.jump             = j;
        bus.conditional_jump = cj;
        bus.jump_address     = ja;
        bus.zero_flag        = zf;
        bus.halt_req         = hr;
        bus.step_req         = sr;
        push(name, epc, epm, eh, ehd, eret);
    endtask

    initial begin
        reset                = 1'b1;
        bus.jump             = 1'b0;
        bus.conditional_jump = 1'b0;
        bus.jump_address     = 4'h0;
        bus.zero_flag        = 1'b0;
        bus.halt_req         = 1'b0;
        bus.step_req         = 1'b0;

        cyc("reset", 1, 0,0,4'h0,0, 0,0,  4'h0, 4'h0, 1, 0, 8'd0);
        cyc("boot",  0, 0,0,4'h0,0, 0,0,  4'h0, 4'h0, 1, 0, 8'd0);
        for (int i = 0; i <= 18; i++)
            cyc("seq", 0, 0,0,4'h0,0, 0,0, 4'(i), 4'(i + 1), 0, 0, 8'(i));

        cyc("jmp9",   0, 1,0,4'h9,0, 0,0,  4'h3, 4'h9, 0, 0, 8'd19);
        cyc("jmp5",   0, 1,0,4'h5,0, 0,0,  4'h9, 4'h5, 0, 0, 8'd20);
        cyc("cj_nz",  0, 0,1,4'hC,0, 0,0,  4'h5, 4'hC, 0, 0, 8'd21);
        cyc("jmp5b",  0, 1,0,4'h5,0, 0,0,  4'hC, 4'h5, 0, 0, 8'd22);
        cyc("cj_z",   0, 0,1,4'hC,1, 0,0,  4'h5, 4'h6, 0, 0, 8'd23);
        cyc("seq6",   0, 0,0,4'h0,0, 0,0,  4'h6, 4'h7, 0, 0, 8'd24);
        cyc("jmp4",   0, 1,0,4'h4,0, 0,0,  4'h7, 4'h4, 0, 0, 8'd25);
        cyc("halt_rq",0, 0,0,4'h0,0, 1,0,  4'h4, 4'h5, 0, 0, 8'd26);
`ifdef PS_DEBUG_EN
        cyc("halt",    0, 0,0,4'h0,0, 1,0,  4'h5, 4'h5, 1, 1, 8'd27);
        cyc("halt_jmp",0, 1,0,4'hF,0, 1,0,  4'h5, 4'h5, 1, 1, 8'd27);
        cyc("step_rq", 0, 0,0,4'h0,0, 1,1,  4'h5, 4'h5, 1, 1, 8'd27);
        cyc("step",    0, 0,0,4'h0,0, 1,0,  4'h5, 4'h6, 0, 0, 8'd27);
        cyc("rehalt",  0, 0,0,4'h0,0, 0,0,  4'h6, 4'h6, 1, 1, 8'd28);
        cyc("resume",  0, 0,0,4'h0,0, 0,0,  4'h6, 4'h7, 0, 0, 8'd28);
`else
        cyc("ign_dbg", 0, 0,0,4'h0,0, 1,1,  4'h5, 4'h6, 0, 0, 8'd27);
        cyc("ign_dbg2",0, 0,0,4'h0,0, 1,0,  4'h6, 4'h7, 0, 0, 8'd28);
`endif
        cyc("run7",    0, 0,0,4'h0,0, 0,1,  4'h7, 4'h8, 0, 0, 8'd29);

        // Reset lands between edges while a jump is being presented.
        @(posedge clk);
        #1;
        bus.step_req     = 1'b0;
        bus.jump         = 1'b1;
        bus.jump_address = 4'hA;
        push("async_rst", 4'h0, 4'h0, 1, 0, 8'd0);
        #2;
        reset = 1'b1;

        cyc("rst_hold", 1, 0,0,4'h0,0, 0,0, 4'h0, 4'h0, 1, 0, 8'd0);
        cyc("boot2",    0, 0,0,4'h0,0, 0,0, 4'h0, 4'h0, 1, 0, 8'd0);
        for (int i = 0; i <= 260; i++)
            cyc("run2", 0, 0,0,4'h0,0, 0,0, 4'(i), 4'(i + 1), 0, 0, 8'(i));

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
